// File: rtl/axi_write_data_burst_if.sv
// rtl/axi_write_data_burst_if.sv - AXI3 write-data channel signal bundle
interface axi_write_data_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) ();
  logic [ID_WIDTH-1:0]     WID;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  modport master (
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY
  );

  modport slave (
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY
  );
endinterface

// File: rtl/axi_write_data_burst.sv
// rtl/axi_write_data_burst.sv - AXI3 W-channel burst master with prefetch beat FIFO
module axi_write_data_burst #(
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int LEN_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int STRB_ENABLE = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          go,
  input  logic [LEN_WIDTH-1:0]          burst_len,
  input  logic [ID_WIDTH-1:0]           transaction_id,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [DATA_WIDTH/8-1:0]       strb,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          done,
  output logic                          data_sent,
  output logic [LEN_WIDTH:0]            beat_count,
  axi_write_data_burst_if.master        w,
  output logic [1:0]                    current_state_out
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]        DEPTH_L  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]        PTR_ONE  = (AW+1)'(1);
  localparam logic [LEN_WIDTH:0] BEAT_ONE = (LEN_WIDTH+1)'(1);

  // Reject unsupported widths and depths when the design is elaborated
  generate
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64 || DATA_WIDTH == 128 ||
          DATA_WIDTH == 256 || DATA_WIDTH == 512 || DATA_WIDTH == 1024)) begin : g_bad_data_width
      $error("axi_write_data_burst: DATA_WIDTH must be 32/64/128/256/512/1024");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("axi_write_data_burst: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RUN      = 2'b01,
    S_COMPLETE = 2'b10
  } state_t;

  state_t state, state_next;

  // Beat FIFO storage; pointers carry one extra bit so full and empty differ
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [STRB_W-1:0]     strb_mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic                  full, empty, push, pop;

  logic [ID_WIDTH-1:0]   wid_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  last_beat;

  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == DEPTH_L);
  assign empty      = (level == '0);
  assign push       = data_valid && !full;
  assign pop        = w.WVALID && w.WREADY;
  assign data_ready = !full;
  assign fifo_level = level;
  assign data_sent  = pop;
  assign last_beat  = (beat_count == {1'b0, len_q});

  // Head of the FIFO drives the bus; zero when nothing is stored
  assign w.WID   = wid_q;
  assign w.WDATA = empty ? '0 : data_mem[rd_ptr[AW-1:0]];
  assign w.WSTRB = empty ? '0 : ((STRB_ENABLE != 0) ? strb_mem[rd_ptr[AW-1:0]] : '1);
  assign w.WLAST = w.WVALID && last_beat;

  // FIFO pointers advance on accepted pushes and on W handshakes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage write; contents are don't-care until a push marks them valid
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr[AW-1:0]] <= data;
      strb_mem[wr_ptr[AW-1:0]] <= strb;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state: start on go, finish on the last handshake, rearm once go drops
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (go) state_next = S_RUN;
      S_RUN:      if (pop && last_beat) state_next = S_COMPLETE;
      S_COMPLETE: if (!go) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State decodes: WVALID only in RUN with a stored beat, done only in COMPLETE
  always_comb begin
    w.WVALID          = 1'b0;
    done              = 1'b0;
    current_state_out = state;
    case (state)
      S_RUN:      w.WVALID = !empty;
      S_COMPLETE: done     = 1'b1;
      default:    ;
    endcase
  end

  // Burst bookkeeping: latch ID/length at start, count beats, clear ID at the end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wid_q      <= '0;
      len_q      <= '0;
      beat_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            wid_q      <= transaction_id;
            len_q      <= burst_len;
            beat_count <= '0;
          end
        end
        S_RUN: begin
          if (pop) begin
            beat_count <= beat_count + BEAT_ONE;
            if (last_beat) wid_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_data_burst.sv
// tb/tb_axi_write_data_burst.sv - randomized model-checked bench for axi_write_data_burst
module tb_axi_write_data_burst;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic [3:0]  burst_len;
  logic [3:0]  transaction_id;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        data_valid;
  logic        data_ready, done, data_sent;
  logic [2:0]  fifo_level;
  logic [4:0]  beat_count;
  logic [1:0]  current_state_out;
  logic        data_ready2, done2, data_sent2;
  logic [2:0]  fifo_level2;
  logic [4:0]  beat_count2;
  logic [1:0]  current_state_out2;

  axi_write_data_burst_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) w1 ();
  axi_write_data_burst_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) w2 ();
  assign w2.WREADY = w1.WREADY;

  always #5 clk = ~clk;

  axi_write_data_burst #(.DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4), .FIFO_DEPTH(FD), .STRB_ENABLE(1)) dut (
    .clk(clk), .resetn(resetn), .go(go), .burst_len(burst_len), .transaction_id(transaction_id),
    .data(data), .strb(strb), .data_valid(data_valid), .data_ready(data_ready), .fifo_level(fifo_level),
    .done(done), .data_sent(data_sent), .beat_count(beat_count), .w(w1), .current_state_out(current_state_out)
  );

  axi_write_data_burst #(.DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4), .FIFO_DEPTH(FD), .STRB_ENABLE(0)) dut_nostrb (
    .clk(clk), .resetn(resetn), .go(go), .burst_len(burst_len), .transaction_id(transaction_id),
    .data(data), .strb(strb), .data_valid(data_valid), .data_ready(data_ready2), .fifo_level(fifo_level2),
    .done(done2), .data_sent(data_sent2), .beat_count(beat_count2), .w(w2), .current_state_out(current_state_out2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: beats waiting in order, plus burst phase 0=idle 1=run 2=complete
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  int m_state, m_count, m_len, m_id;
  bit last_push, last_pop;

  function automatic bit exp_wvalid();
    return (m_state == 1) && (q_data.size() > 0);
  endfunction
  function automatic bit exp_wlast();
    return exp_wvalid() && (m_count == m_len);
  endfunction
  function automatic logic [31:0] exp_wdata();
    return (q_data.size() > 0) ? q_data[0] : 32'h0;
  endfunction
  function automatic logic [3:0] exp_wstrb();
    return (q_strb.size() > 0) ? q_strb[0] : 4'h0;
  endfunction

  task automatic model_reset();
    q_data.delete();
    q_strb.delete();
    m_state = 0; m_count = 0; m_len = 0; m_id = 0;
    last_push = 0; last_pop = 0;
  endtask

  // Advance one clock edge and apply the burst rules to the model
  task automatic advance();
    bit pop, push, last;
    pop  = exp_wvalid() && (w1.WREADY === 1'b1);
    push = (data_valid === 1'b1) && (q_data.size() < FD);
    last = (m_count == m_len);
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      last_pop = pop;
      last_push = push;
      case (m_state)
        0: if (go) begin m_state = 1; m_count = 0; m_len = burst_len; m_id = transaction_id; end
        1: if (pop) begin m_count++; if (last) begin m_state = 2; m_id = 0; end end
        2: if (!go) m_state = 0;
        default: m_state = 0;
      endcase
      if (pop) begin void'(q_data.pop_front()); void'(q_strb.pop_front()); end
      if (push) begin q_data.push_back(data); q_strb.push_back(strb); end
    end
    #1;
  endtask

  task automatic idle_inputs();
    go = 0; data_valid = 0; w1.WREADY = 0;
  endtask

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      data_valid = 1; data = $urandom; strb = 4'($urandom_range(0, 15));
      advance();
    end
    data_valid = 0;
  endtask

  task automatic test_reset();
    resetn = 0; idle_inputs(); burst_len = 0; transaction_id = 0; data = 0; strb = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    vectors++; if (current_state_out !== 2'b00) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", current_state_out); end
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", data_ready); end
    vectors++; if (w1.WDATA !== 32'h0 || w1.WVALID !== 1'b0) begin miscompares++; $display("FAIL reset_bus: got data %h valid %b expected 0/0", w1.WDATA, w1.WVALID); end
    #1;
    // mid-burst reset while beat 2 of 4 is on the bus
    push_beats(4);
    go = 1; burst_len = 3; transaction_id = 4'h6; w1.WREADY = 1;
    advance();
    go = 0;
    advance();
    vectors++; if (m_count != 1 || w1.WVALID !== 1'b1) begin miscompares++; $display("FAIL reset_setup: got valid %b beats %0d expected 1/1", w1.WVALID, m_count); end
    resetn = 0;
    #1;
    model_reset();
    vectors++; if (current_state_out !== 2'b00) begin miscompares++; $display("FAIL async_state: got %0d expected 0", current_state_out); end
    vectors++; if (w1.WVALID !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL async_flags: got valid %b done %b expected 0/0", w1.WVALID, done); end
    vectors++; if (fifo_level !== 3'd0 || w1.WID !== 4'h0 || beat_count !== 5'd0) begin miscompares++; $display("FAIL async_regs: got level %0d wid %h beats %0d expected 0/0/0", fifo_level, w1.WID, beat_count); end
    advance();
    resetn = 1; w1.WREADY = 0;
    @(negedge clk);
    vectors++; if (data_ready !== 1'b1 || fifo_level !== 3'd0) begin miscompares++; $display("FAIL release_ready: got ready %b level %0d expected 1/0", data_ready, fifo_level); end
    advance();
  endtask

  task automatic test_prefetch();
    int beats;
    push_beats(4);
    @(negedge clk);
    vectors++; if (fifo_level !== 3'd4 || data_ready !== 1'b0) begin miscompares++; $display("FAIL prefetch_full: got level %0d ready %b expected 4/0", fifo_level, data_ready); end
    go = 1; burst_len = 3; transaction_id = 4'hA; w1.WREADY = 1;
    advance();
    go = 0;
    beats = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (w1.WVALID !== 1'b1 || data_sent !== 1'b1) begin miscompares++; $display("FAIL prefetch_valid%0d: got valid %b sent %b expected 1/1", c, w1.WVALID, data_sent); end
      vectors++; if (w1.WDATA !== exp_wdata() || w1.WSTRB !== exp_wstrb()) begin miscompares++; $display("FAIL prefetch_data%0d: got %h/%h expected %h/%h", c, w1.WDATA, w1.WSTRB, exp_wdata(), exp_wstrb()); end
      vectors++; if (w1.WLAST !== (c == 3) || w1.WID !== 4'hA) begin miscompares++; $display("FAIL prefetch_last%0d: got last %b wid %h expected %b/a", c, w1.WLAST, w1.WID, c == 3); end
      advance();
      beats++;
    end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || current_state_out !== 2'b10) begin miscompares++; $display("FAIL prefetch_done: got done %b state %0d expected 1/2", done, current_state_out); end
    vectors++; if (beat_count !== 5'(beats) || w1.WID !== 4'h0 || w1.WVALID !== 1'b0) begin miscompares++; $display("FAIL prefetch_end: got beats %0d wid %h valid %b expected %0d/0/0", beat_count, w1.WID, w1.WVALID, beats); end
    advance();
    w1.WREADY = 0;
  endtask

  task automatic test_stall();
    logic [31:0] hold_data;
    logic [3:0]  hold_strb;
    logic        hold_last;
    int          guard;
    push_beats(4);
    go = 1; burst_len = 3; transaction_id = 4'hC; w1.WREADY = 1;
    advance();
    go = 0;
    advance();
    w1.WREADY = 0;
    hold_data = exp_wdata(); hold_strb = exp_wstrb(); hold_last = exp_wlast();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (w1.WVALID !== 1'b1 || data_sent !== 1'b0) begin miscompares++; $display("FAIL stall_hs%0d: got valid %b sent %b expected 1/0", c, w1.WVALID, data_sent); end
      vectors++; if (w1.WDATA !== hold_data || w1.WSTRB !== hold_strb || w1.WLAST !== hold_last) begin miscompares++; $display("FAIL stall_hold%0d: got %h/%h/%b expected %h/%h/%b", c, w1.WDATA, w1.WSTRB, w1.WLAST, hold_data, hold_strb, hold_last); end
      advance();
    end
    w1.WREADY = 1;
    guard = 0;
    while (m_state != 2 && guard < 20) begin
      @(negedge clk);
      vectors++; if (w1.WDATA !== exp_wdata() || w1.WLAST !== exp_wlast()) begin miscompares++; $display("FAIL stall_resume: got %h/%b expected %h/%b", w1.WDATA, w1.WLAST, exp_wdata(), exp_wlast()); end
      advance();
      guard++;
    end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || beat_count !== 5'd4) begin miscompares++; $display("FAIL stall_done: got done %b beats %0d expected 1/4", done, beat_count); end
    advance();
    w1.WREADY = 0;
  endtask

  task automatic test_single_beat();
    data_valid = 1; data = $urandom; strb = 4'h3;
    advance();
    data_valid = 0; go = 1; burst_len = 0; transaction_id = 4'h7; w1.WREADY = 1;
    advance();
    go = 0;
    @(negedge clk);
    vectors++; if (w1.WVALID !== 1'b1 || w1.WLAST !== 1'b1 || data_sent !== 1'b1) begin miscompares++; $display("FAIL single_hs: got valid %b last %b sent %b expected 1/1/1", w1.WVALID, w1.WLAST, data_sent); end
    vectors++; if (w1.WSTRB !== 4'h3 || w1.WDATA !== exp_wdata()) begin miscompares++; $display("FAIL single_strb: got %h/%h expected 3/%h", w1.WSTRB, w1.WDATA, exp_wdata()); end
    vectors++; if (w2.WVALID !== 1'b1 || w2.WSTRB !== 4'hF) begin miscompares++; $display("FAIL nostrb_wstrb: got valid %b strb %h expected 1/f", w2.WVALID, w2.WSTRB); end
    advance();
    @(negedge clk);
    vectors++; if (done !== 1'b1 || beat_count !== 5'd1) begin miscompares++; $display("FAIL single_done: got done %b beats %0d expected 1/1", done, beat_count); end
    advance();
    w1.WREADY = 0;
  endtask

  task automatic test_streaming(input int len, input int npush);
    int  pushed, beats, lvl0, max_lvl;
    bit  seen_done;
    lvl0 = q_data.size(); pushed = 0; beats = 0; max_lvl = 0; seen_done = 0;
    go = 1; burst_len = 4'(len); transaction_id = 4'($urandom_range(1, 15));
    for (int cyc = 0; cyc < 800; cyc++) begin
      data_valid = (pushed < npush) && ($urandom_range(0, 2) != 0);
      data = $urandom; strb = 4'($urandom_range(0, 15));
      w1.WREADY = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      vectors++; if (w1.WVALID !== exp_wvalid() || w1.WLAST !== exp_wlast()) begin miscompares++; $display("FAIL stream_ctl: got valid %b last %b expected %b/%b", w1.WVALID, w1.WLAST, exp_wvalid(), exp_wlast()); end
      vectors++; if (w1.WDATA !== exp_wdata() || w1.WSTRB !== exp_wstrb()) begin miscompares++; $display("FAIL stream_data: got %h/%h expected %h/%h", w1.WDATA, w1.WSTRB, exp_wdata(), exp_wstrb()); end
      vectors++; if (fifo_level !== 3'(q_data.size()) || data_ready !== (q_data.size() < FD)) begin miscompares++; $display("FAIL stream_level: got %0d/%b expected %0d", fifo_level, data_ready, q_data.size()); end
      vectors++; if (current_state_out !== 2'(m_state) || done !== (m_state == 2)) begin miscompares++; $display("FAIL stream_state: got %0d/%b expected %0d", current_state_out, done, m_state); end
      vectors++; if (w1.WID !== 4'(m_id) || beat_count !== 5'(m_count) || data_sent !== (exp_wvalid() && w1.WREADY)) begin miscompares++; $display("FAIL stream_regs: got wid %h beats %0d sent %b expected %h/%0d", w1.WID, beat_count, data_sent, m_id, m_count); end
      if (m_state == 2 && !seen_done) begin
        vectors++; if (beat_count !== 5'(len + 1)) begin miscompares++; $display("FAIL stream_count: got %0d expected %0d", beat_count, len + 1); end
      end
      if (int'(fifo_level) > max_lvl) max_lvl = fifo_level;
      advance();
      go = 0;
      if (last_push) pushed++;
      if (last_pop) beats++;
      if (m_state == 2) seen_done = 1;
      if (seen_done && m_state == 0 && pushed == npush) break;
    end
    w1.WREADY = 0; data_valid = 0;
    @(negedge clk);
    vectors++; if (!seen_done || pushed != npush) begin miscompares++; $display("FAIL stream_timeout: done %b pushed %0d expected 1/%0d", seen_done, pushed, npush); end
    vectors++; if (beats != len + 1) begin miscompares++; $display("FAIL stream_beats: got %0d expected %0d", beats, len + 1); end
    vectors++; if (fifo_level !== 3'(lvl0 + npush - len - 1) || max_lvl > FD) begin miscompares++; $display("FAIL stream_leftover: got %0d max %0d expected %0d max %0d", fifo_level, max_lvl, lvl0 + npush - len - 1, FD); end
    advance();
  endtask

  task automatic test_go_rules();
    int pushed, guard;
    go = 1; burst_len = 2; transaction_id = 4'h5; data_valid = 0; w1.WREADY = 1;
    advance();
    go = 0;
    pushed = 0; guard = 0;
    while (m_state != 2 && guard < 40) begin
      data_valid = (pushed < 3); data = $urandom; strb = 4'($urandom_range(0, 15));
      @(negedge clk);
      vectors++; if (current_state_out !== 2'b01 || w1.WVALID !== exp_wvalid()) begin miscompares++; $display("FAIL go_drop_run: got state %0d valid %b expected 1/%b", current_state_out, w1.WVALID, exp_wvalid()); end
      advance();
      if (last_push) pushed++;
      guard++;
    end
    data_valid = 0;
    go = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (current_state_out !== 2'b10 || done !== 1'b1 || beat_count !== 5'd3) begin miscompares++; $display("FAIL go_hold_complete%0d: got state %0d done %b beats %0d expected 2/1/3", c, current_state_out, done, beat_count); end
      advance();
    end
    go = 0;
    advance();
    @(negedge clk);
    vectors++; if (current_state_out !== 2'b00 || done !== 1'b0) begin miscompares++; $display("FAIL go_release: got state %0d done %b expected 0/0", current_state_out, done); end
    go = 1; burst_len = 0; transaction_id = 4'h3; data_valid = 1; data = $urandom; strb = 4'hF;
    advance();
    go = 0; data_valid = 0;
    @(negedge clk);
    vectors++; if (current_state_out !== 2'b01 || beat_count !== 5'd0 || w1.WID !== 4'h3) begin miscompares++; $display("FAIL go_second: got state %0d beats %0d wid %h expected 1/0/3", current_state_out, beat_count, w1.WID); end
    advance();
    @(negedge clk);
    vectors++; if (done !== 1'b1 || beat_count !== 5'd1 || fifo_level !== 3'd0) begin miscompares++; $display("FAIL go_second_done: got done %b beats %0d level %0d expected 1/1/0", done, beat_count, fifo_level); end
    advance();
    w1.WREADY = 0;
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_stall();
    test_single_beat();
    test_streaming(7, 9);
    test_streaming(15, 15);
    test_go_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_write_data_burst.md
# axi_write_data_burst

Parametrised AXI3 write-data channel master that sends one burst of `burst_len`+1 beats per `go` request, behind an internal beat FIFO. The upstream source can prefetch write beats before the burst starts. The block counts beats itself: it generates WLAST and drives per-beat byte strobes, so the source never signals the last transfer. It sits between the address-channel sequencer, which provides `go`, `burst_len` and `transaction_id`, and the AXI interconnect W channel.

## Interface
Parameters:
- DATA_WIDTH, 32, W data width; must be 32/64/128/256/512/1024, otherwise elaboration error
- ID_WIDTH, 4, width of WID
- LEN_WIDTH, 4, burst length field width (AXI3 AWLEN)
- FIFO_DEPTH, 4, beat FIFO entries; power of two, ≥2
- STRB_ENABLE, 1, 1 = WSTRB from `strb` input; 0 = WSTRB all ones

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- go  in  1  level request; sampled in IDLE
- burst_len  in  LEN_WIDTH  beats minus one; latched with go
- transaction_id  in  ID_WIDTH  burst ID; latched with go
- data  in  DATA_WIDTH  write beat data
- strb  in  DATA_WIDTH/8  write beat byte enables
- data_valid  in  1  source beat valid
- data_ready  out  1  FIFO not full
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries
- done  out  1  burst complete, held until go low
- data_sent  out  1  one-cycle pulse per W beat accepted
- beat_count  out  LEN_WIDTH+1  beats accepted in current burst
- WID  out  ID_WIDTH
- WDATA  out  DATA_WIDTH
- WSTRB  out  DATA_WIDTH/8
- WLAST  out  1
- WVALID  out  1
- WREADY  in  1
- current_state_out  out  2  IDLE=00, RUN=01, COMPLETE=10, 11 unused

## Operation
- **Reset.** Asynchronous on resetn low, including mid-burst. FIFO is flushed (fifo_level=0). State goes to IDLE. WID, beat_count and the latched length are cleared to 0. done, data_sent, WVALID and WLAST are 0. data_ready is 1 once resetn is high. WDATA/WSTRB are 0 while the FIFO is empty.
- **FIFO push.** A push happens when data_valid && data_ready, in every state. data_ready = !full.
- **FIFO pop.** A pop happens only on a W handshake (WVALID && WREADY).
- **Simultaneous push and pop.** Allowed whenever not full; fifo_level is unchanged.
- **FIFO full.** Push is refused. No overwrite of stored entries.
- **Pointer wrap.** Pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.
- **IDLE.** When go=1:
  - capture transaction_id into WID and burst_len into the length register;
  - set beat_count to 0;
  - go to RUN.
- **RUN.**
  - WVALID = !empty. WDATA and WSTRB come from the FIFO head.
  - WLAST = WVALID && (beat_count == latched length).
  - On each handshake: data_sent=1, beat_count increments.
  - On the handshake with WLAST=1: go to COMPLETE and clear WID to 0.
- **COMPLETE.** done=1 and WVALID=0. When go=0, go to IDLE. beat_count holds its final value until the next start.
- **AXI stability.** Once WVALID=1, WDATA, WSTRB, WLAST and WVALID stay stable until WREADY. The head entry cannot change without a pop, and the state cannot leave RUN without the last pop.
- **Beats in excess of the burst.** Extra beats stay in the FIFO for the next burst. Each burst consumes exactly burst_len+1 beats.
- **go in RUN.** go is ignored while in RUN. Dropping go mid-burst does not abort the burst.

## Timing
- **Push to WVALID.** A push into an empty FIFO in RUN gives WVALID=1 on the next cycle (1-cycle latency).
- **FIFO primed at start.** go=1 in IDLE puts the block in RUN on the next cycle. WVALID=1 in that same cycle if the FIFO is non-empty.
- **Back-to-back beats.** With WREADY held high and the FIFO non-empty, one beat transfers per cycle.
- **Last beat.** The last handshake occurs at edge N. On cycle N+1: state=COMPLETE, done=1, WID=0, WVALID=0.
- **Leaving COMPLETE.** go=0 sampled in COMPLETE gives IDLE on the next cycle. A new burst needs go low for at least one sampled cycle.
- **Minimum burst.** burst_len=0 gives a single beat with WLAST=1.
- **Maximum burst.** burst_len=2^LEN_WIDTH−1 gives beat_count reaching 2^LEN_WIDTH in COMPLETE. No overflow, thanks to the extra bit.
- **data_sent.** Combinational with the handshake, high in the same cycle.
- **Other flags.** done and current_state_out are registered-state decodes.

## Test plan
- **Reset values.** Assert resetn=0 mid-burst (beat 2 of 4) → next cycle state=00, WVALID=0, fifo_level=0, WID=0, done=0. After release, data_ready=1.
- **Prefetch burst.** Push 4 beats in IDLE (fifo_level=4, data_ready=0), then go with burst_len=3, transaction_id=0xA, WREADY=1 → 4 consecutive beats, WID=0xA, WLAST only on beat 4, done=1 the following cycle, beat_count=4.
- **WREADY stall.** Hold WREADY=0 for 3 cycles on beat 2 → WDATA, WSTRB and WLAST stable with WVALID=1 throughout; no data_sent pulses during the stall.
- **Single-beat burst and strobes.** burst_len=0, strb=0x3 with STRB_ENABLE=1 → one beat, WLAST=1, WSTRB=0x3. With STRB_ENABLE=0 → WSTRB=0xF.
- **Streaming through the FIFO.** burst_len=7, FIFO_DEPTH=4, random data_valid and WREADY → exactly 8 beats in order, no loss or duplication; fifo_level never above 4; a 9th pushed beat remains in the FIFO after done.
- **Handshake rules for go.** Drop go mid-RUN → burst still completes. Hold go high in COMPLETE → state stays COMPLETE. Release go → IDLE next cycle, then a new go starts burst 2 with beat_count reset to 0.
